// File: rtl/sdram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_cmd_arbiter
//  Description : Shares the SDRAM command/address/data pins between the init
//                sequencer, auto-refresh, burst-write and burst-read engines.
//                Fixed priority refresh > write > read, with a write-streak
//                limit so a pending read is eventually forced through.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_cmd_arbiter #(
    parameter int WR_STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        rstn,
    // init sequencer
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    // auto-refresh engine
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,
    // burst-write engine
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [12:0] wr_addr,
    input  logic        wr_dq_oe,
    input  logic [15:0] wr_dq,
    // burst-read engine
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [12:0] rd_addr,
    // grants
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    // SDRAM pins
    output logic        sdram_cke,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ARBIT = 3'd1;
    localparam logic [2:0] c_ST_AREF  = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_READ  = 3'd4;

    localparam logic [3:0]  c_STREAK_MAX = 4'(WR_STREAK_MAX);
    localparam logic [3:0]  c_NOP_CMD    = 4'b0111;
    localparam logic [1:0]  c_NOP_BA     = 2'b11;
    localparam logic [12:0] c_NOP_ADDR   = 13'h1FFF;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [3:0] r_streak;

    // Next-state decision; a grant is only left on its own *_end pulse.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (init_end) w_state_nxt = c_ST_ARBIT;
            end
            c_ST_ARBIT: begin
                if (aref_req)                                w_state_nxt = c_ST_AREF;
                else if (rd_req && (r_streak == c_STREAK_MAX)) w_state_nxt = c_ST_READ;
                else if (wr_req)                             w_state_nxt = c_ST_WRITE;
                else if (rd_req)                             w_state_nxt = c_ST_READ;
            end
            c_ST_AREF: begin
                if (aref_end) w_state_nxt = c_ST_ARBIT;
            end
            c_ST_WRITE: begin
                if (wr_end) w_state_nxt = c_ST_ARBIT;
            end
            c_ST_READ: begin
                if (rd_end) w_state_nxt = c_ST_ARBIT;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Count writes granted while a read waits; any read grant resets the streak.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_streak <= 4'd0;
        end else if (r_state == c_ST_ARBIT) begin
            if (w_state_nxt == c_ST_WRITE) begin
                if (!rd_req)                        r_streak <= 4'd0;
                else if (r_streak >= c_STREAK_MAX)  r_streak <= c_STREAK_MAX;
                else                                r_streak <= r_streak + 4'd1;
            end else if (w_state_nxt == c_ST_READ) begin
                r_streak <= 4'd0;
            end
        end
    end

    // Command/address mux and DQ gating, decoded purely from the state register.
    always_comb begin
        sdram_cmd    = c_NOP_CMD;
        sdram_ba     = c_NOP_BA;
        sdram_addr   = c_NOP_ADDR;
        sdram_dq_out = 16'h0000;
        sdram_dq_oe  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            c_ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            c_ST_WRITE: begin
                sdram_cmd    = wr_cmd;
                sdram_ba     = wr_ba;
                sdram_addr   = wr_addr;
                sdram_dq_out = wr_dq;
                sdram_dq_oe  = wr_dq_oe;
            end
            c_ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign aref_en   = (r_state == c_ST_AREF);
    assign wr_en     = (r_state == c_ST_WRITE);
    assign rd_en     = (r_state == c_ST_READ);
    assign sdram_cke = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sdram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_cmd_arbiter
//  Description : Directed self-checking bench for sdram_cmd_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdram_cmd_arbiter;

    localparam int M_IDLE  = 0;
    localparam int M_ARBIT = 1;
    localparam int M_AREF  = 2;
    localparam int M_WRITE = 3;
    localparam int M_READ  = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
    logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
    logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic        wr_dq_oe;
    logic [15:0] wr_dq;
    logic        aref_en, wr_en, rd_en, sdram_cke, sdram_dq_oe;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_cmd_arbiter #(.WR_STREAK_MAX(4)) dut (
        .clk(clk), .rstn(rstn),
        .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
        .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_dq_oe(wr_dq_oe), .wr_dq(wr_dq),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba),
        .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 clk = ~clk;

    // Expected {aref_en,wr_en,rd_en,cke,cmd,ba,addr,dq_oe,dq_out} for a given mode,
    // built from the fixed per-engine bus values driven below.
    function automatic logic [39:0] expect_of(input int mode);
        logic [39:0] e;
        case (mode)
            M_IDLE:  e = {3'b000, 1'b1, 4'b0010, 2'd0, 13'h0400, 1'b0, 16'h0000};
            M_AREF:  e = {3'b100, 1'b1, 4'b0001, 2'd1, 13'h0AAA, 1'b0, 16'h0000};
            M_WRITE: e = {3'b010, 1'b1, 4'b0100, 2'd2, 13'h0123, 1'b1, 16'hA5A5};
            M_READ:  e = {3'b001, 1'b1, 4'b0101, 2'd3, 13'h0456, 1'b0, 16'h0000};
            default: e = {3'b000, 1'b1, 4'b0111, 2'd3, 13'h1FFF, 1'b0, 16'h0000};
        endcase
        return e;
    endfunction

    task automatic check_mode(input string tag, input int mode);
        logic [39:0] obs;
        logic [39:0] exp_v;
        obs   = {aref_en, wr_en, rd_en, sdram_cke, sdram_cmd, sdram_ba, sdram_addr,
                 sdram_dq_oe, sdram_dq_out};
        exp_v = expect_of(mode);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stay in a grant for 8 cycles total, pulse the matching end, then expect one NOP cycle.
    task automatic finish_burst(input string tag, input int mode);
        for (int k = 1; k < 8; k++) begin
            tick();
            check_mode({tag, "_hold"}, mode);
        end
        if (mode == M_WRITE) wr_end = 1'b1;
        else if (mode == M_READ) rd_end = 1'b1;
        else aref_end = 1'b1;
        tick();
        wr_end = 1'b0; rd_end = 1'b0; aref_end = 1'b0;
        check_mode({tag, "_nop"}, M_ARBIT);
    endtask

    initial begin
        rstn = 1'b0;
        init_end = 1'b0; aref_req = 1'b0; aref_end = 1'b0;
        wr_req = 1'b0; wr_end = 1'b0; rd_req = 1'b0; rd_end = 1'b0;
        init_cmd = 4'b0010; init_ba = 2'd0; init_addr = 13'h0400;
        aref_cmd = 4'b0001; aref_ba = 2'd1; aref_addr = 13'h0AAA;
        wr_cmd   = 4'b0100; wr_ba   = 2'd2; wr_addr   = 13'h0123;
        rd_cmd   = 4'b0101; rd_ba   = 2'd3; rd_addr   = 13'h0456;
        wr_dq_oe = 1'b1; wr_dq = 16'hA5A5;

        // Reset state: init bus muxed, no grants, DQ released
        tick(); tick();
        check_mode("reset_idle", M_IDLE);
        rstn = 1'b1;
        for (int c = 2; c < 10; c++) tick();
        check_mode("idle_no_init_end", M_IDLE);

        // init_end at cycle 10 -> ARBIT, idle NOP with no requests
        init_end = 1'b1;
        tick();
        check_mode("arbit_after_init", M_ARBIT);
        tick();
        check_mode("arbit_idle_nop", M_ARBIT);

        // All three requests together: refresh first
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        check_mode("aref_priority", M_AREF);
        aref_req = 1'b0;
        finish_burst("aref", M_AREF);

        // Write wins after refresh; streak builds to 4 while rd_req waits
        tick();
        check_mode("write1_grant", M_WRITE);
        finish_burst("write1", M_WRITE);
        tick();
        check_mode("write2_grant", M_WRITE);
        finish_burst("write2", M_WRITE);
        tick();
        check_mode("write3_grant", M_WRITE);
        finish_burst("write3", M_WRITE);
        tick();
        check_mode("write4_grant", M_WRITE);
        finish_burst("write4", M_WRITE);

        // Streak limit reached: read forced ahead of the pending write
        tick();
        check_mode("read_forced", M_READ);
        tick();
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        check_mode("read_ignores_wr_end", M_READ);
        tick();
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        check_mode("read_end_nop", M_ARBIT);

        // Streak cleared by the read: write granted again
        tick();
        check_mode("write5_grant", M_WRITE);
        tick();
        check_mode("write5_dq", M_WRITE);

        // Asynchronous reset mid-write
        rstn = 1'b0;
        #1;
        check_mode("async_reset_drop", M_IDLE);
        tick();
        check_mode("reset_held_idle", M_IDLE);
        rstn = 1'b1;
        tick();
        check_mode("arbit_after_reset", M_ARBIT);

        // Streak cleared by reset: write grant, not read
        tick();
        check_mode("write_after_reset", M_WRITE);

        // Only a read pending: read granted directly
        wr_req = 1'b0;
        finish_burst("write6", M_WRITE);
        tick();
        check_mode("read_only_grant", M_READ);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Owns the single SDRAM command/address/data bus and shares it between four requesters: the init sequencer, auto-refresh, the burst-write engine and the burst-read engine.
- Sits between those engines and the SDRAM pins, in the same clk domain as the FIFO control block.
- Grants one engine at a time by fixed priority (refresh > write > read), with a write-streak limit so reads cannot be starved.

Parameters:
- WR_STREAK_MAX, 4: consecutive write grants allowed while rd_req is pending before a read is forced; legal range 1..15.

Ports:
- clk  in  1  controller clock
- rstn  in  1  async active-low reset
- init_end  in  1  init sequencer done; stays high until reset
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init
- init_ba  in  2  bank from init
- init_addr  in  13  address from init
- aref_req  in  1  refresh request, level
- aref_end  in  1  refresh engine done, 1-cycle pulse
- aref_cmd  in  4
- aref_ba  in  2
- aref_addr  in  13
- wr_req  in  1  write request, level (from FIFO control)
- wr_end  in  1  write burst done, pulse
- wr_cmd  in  4
- wr_ba  in  2
- wr_addr  in  13
- wr_dq_oe  in  1  write engine drives DQ
- wr_dq  in  16  write data
- rd_req  in  1  read request, level
- rd_end  in  1  read burst done, pulse
- rd_cmd  in  4
- rd_ba  in  2
- rd_addr  in  13
- aref_en  out  1  refresh grant
- wr_en  out  1  write grant
- rd_en  out  1  read grant
- sdram_cke  out  1  clock enable
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to pins
- sdram_ba  out  2
- sdram_addr  out  13
- sdram_dq_out  out  16  DQ output data
- sdram_dq_oe  out  1  DQ tristate enable

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk. All state is updated on posedge clk.
- State register values: IDLE, ARBIT, AREF, WRITE, READ. Reset state is IDLE.
- Output reset values:
  - aref_en, wr_en, rd_en = 0
  - sdram_dq_oe = 0, sdram_dq_out = 0
  - sdram_cke = 1
  - in IDLE, sdram_cmd/ba/addr follow the init bus
  - streak counter = 0
- IDLE -> ARBIT on the clk edge where init_end = 1. In IDLE only the init bus is muxed out. init_end is not re-checked outside IDLE.
- ARBIT (evaluated each cycle, first match wins):
  1. aref_req -> AREF
  2. rd_req and streak == WR_STREAK_MAX -> READ
  3. wr_req -> WRITE
  4. rd_req -> READ
  5. otherwise stay in ARBIT
- AREF / WRITE / READ: stay until the matching *_end is sampled high, then return to ARBIT on the next edge.
  - Requests raised during a grant are held off; they are evaluated in the following ARBIT cycle.
  - There is always at least one ARBIT (NOP) cycle between grants.
  - *_end pulses that do not match the current state are ignored.
- Grant outputs are decoded from the state register (registered state, no input path):
  - aref_en = (state == AREF)
  - wr_en = (state == WRITE)
  - rd_en = (state == READ)
  - Each grant rises the cycle after the ARBIT decision and falls the cycle after the *_end sample.
- Command mux is combinational from the state register:
  - IDLE: init bus
  - AREF: aref bus
  - WRITE: wr bus
  - READ: rd bus
  - ARBIT: cmd = 4'b0111 (NOP), ba = 2'b11, addr = 13'h1FFF
- DQ path:
  - sdram_dq_oe = wr_dq_oe only in WRITE, else 0
  - sdram_dq_out = wr_dq in WRITE, else 0
- Streak counter, 4-bit, updated on the ARBIT->WRITE transition:
  - increments (saturating at WR_STREAK_MAX) if rd_req = 1
  - clears to 0 if rd_req = 0
  - clears on every ARBIT->READ transition
  - unchanged by AREF
- Simultaneous aref_req, wr_req and rd_req in ARBIT: AREF is granted. The pending write/read is decided in the ARBIT cycle after AREF completes.
- Reset asserted mid-grant: immediate return to IDLE, grants drop to 0 and DQ is released in the same instant (asynchronous). The streak counter is cleared.
- sdram_cke is a constant 1 after reset. Self-refresh is out of scope.

Test Plan:
- Reset then init_end = 1 at cycle 10, no requests -> state ARBIT from cycle 11; sdram_cmd = 4'b0111, sdram_addr = 13'h1FFF, all grants 0.
- aref_req, wr_req and rd_req all = 1 in the same ARBIT cycle -> aref_en = 1 next cycle. After aref_end, one NOP cycle, then wr_en = 1; rd_en stays 0 until the write completes.
- WR_STREAK_MAX = 4, wr_req and rd_req held high, each burst ending 8 cycles after its grant -> write, write, write, write, read, write... Exactly 4 wr_en periods precede the first rd_en.
- In WRITE with wr_dq_oe = 1 and wr_dq = 16'hA5A5 -> sdram_dq_oe = 1 and sdram_dq_out = 16'hA5A5. After wr_end -> sdram_dq_oe = 0 within one cycle.
- During READ, pulse wr_end (a stray pulse) -> no state change. rd_end -> ARBIT next edge.
- rstn low for 1 cycle in the middle of a WRITE -> wr_en and sdram_dq_oe drop to 0 asynchronously, state = IDLE. After rstn returns high with init_end still high, the block is in ARBIT on the next edge.
